// File: rtl/smag_seq_multiplier_p_if.sv
// Operand/result bundle for the sequential sign-magnitude / two's-complement multiplier.
// Handshake: start is a request taken only in IDLE or DONE; busy marks CALC; done pulses one cycle with product valid.
interface smag_seq_multiplier_p_if #(
    parameter int WIDTH = 6
);
    logic                 start;
    logic                 tc_mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;
    logic                 done;
    logic [1:0]           dbg_state;

    modport master (
        output start, tc_mode, a, b,
        input  product, busy, done, dbg_state
    );

    modport slave (
        input  start, tc_mode, a, b,
        output product, busy, done, dbg_state
    );
endinterface

// File: rtl/smag_seq_multiplier_p.sv
// Shift-add multiplier, one multiplier bit per clock, WIDTH iterations, sign-magnitude or two's-complement per operation.
// Magnitudes are multiplied unsigned; the sign is applied once on the final edge.
module smag_seq_multiplier_p #(
    parameter int WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    smag_seq_multiplier_p_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_tc;
    logic                 r_sign;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_accept;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 w_last;
    logic                 w_sign_eff;
    logic [2*WIDTH-1:0]   w_result;

    assign w_accept = bus.start && (r_state == S_IDLE || r_state == S_DONE);

    // TC: -2^(W-1) negates to itself, which read unsigned is exactly 2^(W-1).
    assign w_mag_a = bus.tc_mode ? (bus.a[WIDTH-1] ? -bus.a : bus.a) : {1'b0, bus.a[WIDTH-2:0]};
    assign w_mag_b = bus.tc_mode ? (bus.b[WIDTH-1] ? -bus.b : bus.b) : {1'b0, bus.b[WIDTH-2:0]};

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    // A zero magnitude drops the sign so -0 never leaves the block.
    assign w_sign_eff = r_sign && (w_acc_next != '0);
    assign w_result   = r_tc ? (w_sign_eff ? -w_acc_next : w_acc_next)
                             : {w_sign_eff, w_acc_next[2*WIDTH-2:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_tc      <= 1'b0;
            r_sign    <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_state  <= S_CALC;
                        r_busy   <= 1'b1;
                        r_tc     <= bus.tc_mode;
                        r_sign   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_product <= w_result;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.product   = r_product;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_smag_seq_multiplier_p.sv
// Directed and random bench for smag_seq_multiplier_p: latency/handshake timing, boundary operands, back-to-back, abort.
module tb_smag_seq_multiplier_p;
    localparam int W = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    smag_seq_multiplier_p_if #(.WIDTH(W)) bus ();

    smag_seq_multiplier_p #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;
    logic [2*W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model: plain signed/unsigned arithmetic
    function automatic logic [2*W-1:0] model(input logic tc, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [2*W-1:0] p;
        logic [2*W-1:0] m;
        if (tc) begin
            p = $signed(x) * $signed(y);
            return p;
        end
        m = {{(W+1){1'b0}}, x[W-2:0]} * {{(W+1){1'b0}}, y[W-2:0]};
        if (m == '0) return '0;
        return {x[W-1] ^ y[W-1], m[2*W-2:0]};
    endfunction

    // scoreboard: every done pops one expected product
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            n_done++;
            if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else chk("product", bus.product, exp_q.pop_front());
        end
    end

    // driver: one operation with full handshake timing checks
    task automatic run_op(input logic tc, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        bus.start = 1'b1; bus.tc_mode = tc; bus.a = x; bus.b = y;
        exp_q.push_back(model(tc, x, y));
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < W; i++) begin
            chk("busy_calc", bus.busy, 1);
            chk("done_calc", bus.done, 0);
            if (i == 2) begin
                bus.a = W'($urandom_range(0, 63)); bus.b = W'($urandom_range(0, 63));
                bus.tc_mode = ~tc;
            end
            @(negedge clk);
        end
        chk("done_pulse", bus.done, 1);
        chk("busy_at_done", bus.busy, 0);
        @(negedge clk);
        chk("done_width", bus.done, 0);
    endtask

    initial begin
        int d0;
        bus.start = 1'b0; bus.tc_mode = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        chk("rst_product", bus.product, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_state", bus.dbg_state, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(1'b0, 6'b000101, 6'b100011);
        chk("sm_5x-3", bus.product, 12'h80F);
        run_op(1'b0, 6'd14, 6'd32);
        chk("sm_neg_zero", bus.product, 12'h000);
        run_op(1'b0, 6'b111111, 6'd31);
        chk("sm_-31x31", bus.product, 12'hBC1);
        run_op(1'b1, 6'b100000, 6'b100000);
        chk("tc_min_sq", bus.product, 12'h400);
        run_op(1'b1, 6'b100000, 6'd1);
        chk("tc_min_x1", bus.product, 12'hFE0);
        run_op(1'b1, 6'b111011, 6'd0);
        chk("tc_-5x0", bus.product, 12'h000);

        for (int r = 0; r < 8; r++)
            run_op(1'($urandom_range(0, 1)), W'($urandom_range(0, 63)), W'($urandom_range(0, 63)));

        // back-to-back with start held high; garbage operands mid-CALC
        @(negedge clk);
        bus.start = 1'b1; bus.tc_mode = 1'b1; bus.a = 6'd7; bus.b = 6'b111101;
        exp_q.push_back(model(1'b1, 6'd7, 6'b111101));
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < W; i++) begin
                @(negedge clk);
                chk("b2b_done_low", bus.done, 0);
                bus.a = W'($urandom_range(0, 63)); bus.b = W'($urandom_range(0, 63));
                bus.tc_mode = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            chk("b2b_done_hi", bus.done, 1);
            if (j < 3) begin
                bus.tc_mode = 1'(j & 1); bus.a = W'($urandom_range(0, 63)); bus.b = W'($urandom_range(0, 63));
                exp_q.push_back(model(bus.tc_mode, bus.a, bus.b));
            end else begin
                bus.start = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_end", bus.done, 0);

        // start pulse while busy is ignored
        d0 = n_done;
        @(negedge clk);
        bus.start = 1'b1; bus.tc_mode = 1'b0; bus.a = 6'd9; bus.b = 6'd10;
        exp_q.push_back(model(1'b0, 6'd9, 6'd10));
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 6'd31; bus.b = 6'd31;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2 * W + 4) @(negedge clk);
        chk("busy_ignore_cnt", n_done - d0, 1);
        chk("busy_ignore_prod", bus.product, 12'd90);

        // abort 3 cycles into CALC
        @(negedge clk);
        bus.start = 1'b1; bus.tc_mode = 1'b0; bus.a = 6'd3; bus.b = 6'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        d0 = n_done;
        rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_product", bus.product, 0);
        chk("abort_state", bus.dbg_state, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 3) @(negedge clk);
        chk("abort_no_done", n_done - d0, 0);
        run_op(1'b0, 6'd31, 6'd31);
        chk("after_abort", bus.product, 12'h3C1);

        repeat (2) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
